// File: rtl/snake_engine.sv
// Snake movement/growth core: segment coordinates, move tick, 2-entry direction queue, growth, collisions.
// Define SNAKE_WRAP_EN to make the head wrap around grid edges instead of dying at them.
module snake_engine #(
   parameter int GRID_W    = 44,
   parameter int GRID_H    = 27,
   parameter int MAX_LEN   = 22,
   parameter int START_LEN = 3,
   parameter int START_X   = 24,
   parameter int START_Y   = 14,
   parameter int TICK_DIV  = 10600000,
   localparam int XW = $clog2(GRID_W),
   localparam int YW = $clog2(GRID_H),
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  dir_valid_i,
   input  logic [1:0]            dir_i,
   output logic                  dir_ready_o,
   input  logic                  grow_i,
   output logic [MAX_LEN*XW-1:0] snake_x_o,
   output logic [MAX_LEN*YW-1:0] snake_y_o,
   output logic [LW-1:0]         length_o,
   output logic                  move_tick_o,
   output logic [1:0]            state_o,
   output logic                  lose_o,
   output logic                  win_o
);
   localparam int CW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2, S_WIN = 2'd3} state_t;
   typedef logic [MAX_LEN-1:0][XW-1:0] segx_t;
   typedef logic [MAX_LEN-1:0][YW-1:0] segy_t;

   state_t          state_q, state_d;
   segx_t           seg_x_q, seg_x_d, init_x;
   segy_t           seg_y_q, seg_y_d, init_y;
   logic [LW-1:0]   len_q, len_d, pend_q, pend_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      cur_dir_q, cur_dir_d;
   logic [1:0][1:0] qent_q, qent_d;
   logic [1:0]      qcnt_q, qcnt_d;
   logic            tick_q, tick_d;
   logic            lose_q, lose_d, win_q, win_d;

   logic [LW-1:0]   pend_inc, hit_lim;
   logic [1:0]      last_dir, mv_dir, qcnt_tmp;
   logic [XW-1:0]   nx;
   logic [YW-1:0]   ny;
   logic            move, push, growing, oob, hit;

   // Unused tail slots stack on the last live start segment so they stay on-grid.
   always_comb begin
      for (int i = 0; i < MAX_LEN; i++) begin
         init_x[i] = (i < START_LEN) ? XW'(START_X - i) : XW'(START_X - START_LEN + 1);
         init_y[i] = YW'(START_Y);
      end
   end

   assign dir_ready_o = (qcnt_q != 2'd2);
   assign snake_x_o   = seg_x_q;
   assign snake_y_o   = seg_y_q;
   assign length_o    = len_q;
   assign move_tick_o = tick_q;
   assign state_o     = state_q;
   assign lose_o      = lose_q;
   assign win_o       = win_q;

   always_comb begin
      state_d   = state_q;
      seg_x_d   = seg_x_q;
      seg_y_d   = seg_y_q;
      len_d     = len_q;
      cur_dir_d = cur_dir_q;
      qent_d    = qent_q;
      qcnt_d    = qcnt_q;
      tick_d    = 1'b0;
      nx        = seg_x_q[0];
      ny        = seg_y_q[0];
      oob       = 1'b0;
      hit       = 1'b0;

      pend_inc = (grow_i && (pend_q < LW'(MAX_LEN))) ? pend_q + LW'(1) : pend_q;
      pend_d   = pend_inc;

      move  = (state_q == S_RUN) && (cnt_q == CW'(TICK_DIV - 1));
      cnt_d = (state_q == S_RUN && !move) ? cnt_q + CW'(1) : '0;

      last_dir = (qcnt_q == 2'd0) ? cur_dir_q : ((qcnt_q == 2'd2) ? qent_q[1] : qent_q[0]);
      push     = dir_valid_i && dir_ready_o && (state_q == S_IDLE || state_q == S_RUN) &&
                 (dir_i != last_dir) && (dir_i != (last_dir ^ 2'b10));
      mv_dir   = (qcnt_q != 2'd0) ? qent_q[0] : cur_dir_q;

      // Pop before push so a same-cycle push lands in the freed slot.
      qcnt_tmp = qcnt_q;
      if (move && qcnt_q != 2'd0) begin
         cur_dir_d = qent_q[0];
         qent_d[0] = qent_q[1];
         qcnt_tmp  = qcnt_q - 2'd1;
      end
      if (push) begin
         qent_d[qcnt_tmp[0]] = dir_i;
         qcnt_d = qcnt_tmp + 2'd1;
      end else begin
         qcnt_d = qcnt_tmp;
      end

      case (mv_dir)
         2'd0: begin
            if (seg_x_q[0] == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
               nx = '0;
`else
               oob = 1'b1;
`endif
            end else nx = seg_x_q[0] + XW'(1);
         end
         2'd1: begin
            if (seg_y_q[0] == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
               ny = '0;
`else
               oob = 1'b1;
`endif
            end else ny = seg_y_q[0] + YW'(1);
         end
         2'd2: begin
            if (seg_x_q[0] == '0) begin
`ifdef SNAKE_WRAP_EN
               nx = XW'(GRID_W - 1);
`else
               oob = 1'b1;
`endif
            end else nx = seg_x_q[0] - XW'(1);
         end
         default: begin
            if (seg_y_q[0] == '0) begin
`ifdef SNAKE_WRAP_EN
               ny = YW'(GRID_H - 1);
`else
               oob = 1'b1;
`endif
            end else ny = seg_y_q[0] - YW'(1);
         end
      endcase

      // A non-growing move vacates the tail, so the tail cell is not a hazard.
      growing = (pend_inc != '0) && (len_q < LW'(MAX_LEN));
      hit_lim = growing ? len_q : len_q - LW'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LW'(i) < hit_lim) && seg_x_q[i] == nx && seg_y_q[i] == ny) hit = 1'b1;
      end

      if (move) begin
         tick_d = 1'b1;
         if (oob || hit) begin
            state_d = S_DEAD;
         end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x_d[i] = seg_x_q[i-1];
               seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            if (growing) begin
               len_d  = len_q + LW'(1);
               pend_d = pend_inc - LW'(1);
               if (len_q + LW'(1) == LW'(MAX_LEN)) state_d = S_WIN;
            end
         end
      end

      if (start_i) begin
         state_d   = S_RUN;
         seg_x_d   = init_x;
         seg_y_d   = init_y;
         len_d     = LW'(START_LEN);
         pend_d    = '0;
         cnt_d     = '0;
         cur_dir_d = 2'd0;
         qcnt_d    = '0;
         tick_d    = 1'b0;
      end

      lose_d = (state_d == S_DEAD);
      win_d  = (state_d == S_WIN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         seg_x_q   <= init_x;
         seg_y_q   <= init_y;
         len_q     <= LW'(START_LEN);
         pend_q    <= '0;
         cnt_q     <= '0;
         cur_dir_q <= 2'd0;
         qent_q    <= '0;
         qcnt_q    <= '0;
         tick_q    <= 1'b0;
         lose_q    <= 1'b0;
         win_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_x_q   <= seg_x_d;
         seg_y_q   <= seg_y_d;
         len_q     <= len_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         cur_dir_q <= cur_dir_d;
         qent_q    <= qent_d;
         qcnt_q    <= qcnt_d;
         tick_q    <= tick_d;
         lose_q    <= lose_d;
         win_q     <= win_d;
      end
   end
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine on an 8x6 grid, MAX_LEN=5, TICK_DIV=4, start (3,2) length 3.
module tb_snake_engine;
   localparam int XW = 3, YW = 3, LW = 3, ML = 5;

   logic clk = 1'b0, rst = 1'b0;
   logic start = 1'b0, dir_valid = 1'b0, grow = 1'b0;
   logic [1:0] dir = 2'd0;
   logic dir_ready, move_tick, lose, win;
   logic [ML*XW-1:0] snake_x;
   logic [ML*YW-1:0] snake_y;
   logic [LW-1:0] length;
   logic [1:0] state;
   int n_chk = 0, n_fail = 0;

   snake_engine #(.GRID_W(8), .GRID_H(6), .MAX_LEN(5), .START_LEN(3), .START_X(3), .START_Y(2),
                  .TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start_i(start), .dir_valid_i(dir_valid), .dir_i(dir),
      .dir_ready_o(dir_ready), .grow_i(grow), .snake_x_o(snake_x), .snake_y_o(snake_y),
      .length_o(length), .move_tick_o(move_tick), .state_o(state), .lose_o(lose), .win_o(win));

   always #5 clk = ~clk;

   function automatic logic [31:0] sx(input int i);
      return 32'(snake_x[i*XW +: XW]);
   endfunction
   function automatic logic [31:0] sy(input int i);
      return 32'(snake_y[i*YW +: YW]);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin cyc(1); n++; end while (!move_tick && n < 16);
      chk("tick_timeout", 32'(move_tick), 1);
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   initial begin
      // reset
      cyc(2);
      chk("rst_state", 32'(state), 0);
      chk("rst_len", 32'(length), 3);
      chk("rst_head", {sx(0)[15:0], sy(0)[15:0]}, {16'd3, 16'd2});
      chk("rst_seg2", sx(2), 1);
      chk("rst_flags", {29'd0, move_tick, lose, win}, 0);
      chk("rst_ready", 32'(dir_ready), 1);
      rst = 1'b1;
      cyc(6);
      chk("idle_nomove", {sx(0)[15:0], 15'd0, move_tick}, {16'd3, 16'd0});

      // 1: straight run to the right edge
      pulse_start();
      chk("t1_run", 32'(state), 1);
      cyc(3);
      chk("t1_notick", 32'(move_tick), 0);
      cyc(1);
      chk("t1_tick1", {sx(0)[15:0], 15'd0, move_tick}, {16'd4, 16'd1});
      cyc(1);
      chk("t1_pulse", 32'(move_tick), 0);
      cyc(3);
      chk("t1_x5", {sx(0)[15:0], 15'd0, move_tick}, {16'd5, 16'd1});
      cyc(4);
      chk("t1_x6", sx(0), 6);
      cyc(4);
      chk("t1_x7", {sx(0)[15:0], sx(1)[15:0]}, {16'd7, 16'd6});
      chk("t1_len", 32'(length), 3);
      cyc(4);
`ifdef SNAKE_WRAP_EN
      chk("t1_wrap_x", sx(0), 0);
      chk("t1_wrap_state", 32'(state), 1);
`else
      chk("t1_dead", {30'd0, state}, 2);
      chk("t1_lose", {30'd0, lose, win}, 2);
      chk("t1_frozen", sx(0), 7);
      cyc(8);
      chk("t1_hold", {sx(0)[15:0], 14'd0, state}, {16'd7, 16'd2});
`endif

      // 2: reversal dropped; down then left in one window
      pulse_start();
      dir_valid = 1'b1; dir = 2'd2; cyc(1); dir_valid = 1'b0;
      wait_tick();
      chk("t2_rev_drop", {sx(0)[15:0], sy(0)[15:0]}, {16'd4, 16'd2});
      dir_valid = 1'b1; dir = 2'd1; cyc(1); dir = 2'd2; cyc(1); dir_valid = 1'b0;
      wait_tick();
      chk("t2_down", {sx(0)[15:0], sy(0)[15:0]}, {16'd4, 16'd3});
      wait_tick();
      chk("t2_left", {sx(0)[15:0], sy(0)[15:0]}, {16'd3, 16'd3});

      // 3: queue full after two entries, third dropped
      pulse_start();
      dir_valid = 1'b1; dir = 2'd1; cyc(1); dir = 2'd2; cyc(1);
      chk("t3_full", 32'(dir_ready), 0);
      dir = 2'd3; cyc(1); dir_valid = 1'b0;
      wait_tick();
      chk("t3_m1", {sx(0)[15:0], sy(0)[15:0]}, {16'd3, 16'd3});
      chk("t3_ready", 32'(dir_ready), 1);
      wait_tick();
      chk("t3_m2", {sx(0)[15:0], sy(0)[15:0]}, {16'd2, 16'd3});
      wait_tick();
      chk("t3_m3", {sx(0)[15:0], sy(0)[15:0]}, {16'd1, 16'd3});

      // 4: two grows reach MAX_LEN
      pulse_start();
      grow = 1'b1; cyc(1); grow = 1'b0; cyc(1); grow = 1'b1; cyc(1); grow = 1'b0;
      wait_tick();
      chk("t4_len4", {sx(0)[15:0], 13'd0, length}, {16'd4, 16'd4});
      chk("t4_tail3", sx(3), 1);
      chk("t4_still_run", 32'(state), 1);
      wait_tick();
      chk("t4_len5", {sx(0)[15:0], 13'd0, length}, {16'd5, 16'd5});
      chk("t4_tail4", {sx(4)[15:0], sy(4)[15:0]}, {16'd1, 16'd2});
      chk("t4_win", {28'd0, state, lose, win}, {28'd0, 2'd3, 1'b0, 1'b1});
      cyc(8);
      chk("t4_hold", {sx(0)[15:0], 15'd0, move_tick}, {16'd5, 16'd0});

      // 5a: coil without growth; tail cell is vacated, no collision
      pulse_start();
      dir_valid = 1'b1; dir = 2'd1; grow = 1'b1; cyc(1);
      dir = 2'd2; grow = 1'b0; cyc(1); dir_valid = 1'b0;
      wait_tick();
      chk("t5_m1", {sx(0)[15:0], 13'd0, length}, {16'd3, 16'd4});
      dir_valid = 1'b1; dir = 2'd3; cyc(1); dir_valid = 1'b0;
      wait_tick();
      chk("t5_m2", {sx(0)[15:0], sy(0)[15:0]}, {16'd2, 16'd3});
      wait_tick();
      chk("t5a_m3", {sx(0)[15:0], sy(0)[15:0]}, {16'd2, 16'd2});
      chk("t5a_run", 32'(state), 1);

      // 5b: same coil, growing on the last move hits segment 3
      pulse_start();
      dir_valid = 1'b1; dir = 2'd1; grow = 1'b1; cyc(1);
      dir = 2'd2; grow = 1'b0; cyc(1); dir_valid = 1'b0;
      wait_tick();
      dir_valid = 1'b1; dir = 2'd3; cyc(1); dir_valid = 1'b0;
      wait_tick();
      grow = 1'b1; cyc(1); grow = 1'b0;
      wait_tick();
      chk("t5b_dead", {28'd0, state, lose, win}, {28'd0, 2'd2, 1'b1, 1'b0});
      chk("t5b_frozen", {sx(0)[15:0], sy(0)[15:0]}, {16'd2, 16'd3});
      chk("t5b_len", 32'(length), 4);
      cyc(8);
      chk("t5b_hold", {sx(3)[15:0], sy(3)[15:0]}, {16'd2, 16'd2});
      pulse_start();
      chk("t5b_restart", {28'd0, state, lose, win}, {28'd0, 2'd1, 1'b0, 1'b0});
      chk("t5b_rs_head", {sx(0)[15:0], 13'd0, length}, {16'd3, 16'd3});
      chk("t5b_rs_y", sy(0), 2);

      // 6: start mid-count restarts; grow on the move edge counts; reset mid-count
      cyc(2);
      pulse_start();
      cyc(3);
      chk("t6_restart_cnt", 32'(move_tick), 0);
      grow = 1'b1; cyc(1); grow = 1'b0;
      chk("t6_same_edge", {sx(0)[15:0], 13'd0, length}, {16'd4, 16'd4});
      chk("t6_tick", 32'(move_tick), 1);
      cyc(2);
      rst = 1'b0; cyc(1); rst = 1'b1;
      chk("t6_rst_state", {30'd0, state}, 0);
      chk("t6_rst_pos", {sx(0)[15:0], 13'd0, length}, {16'd3, 16'd3});
      cyc(6);
      chk("t6_idle", {sx(0)[15:0], 15'd0, move_tick}, {16'd3, 16'd0});
      pulse_start();
      cyc(3);
      chk("t6_cnt0", 32'(move_tick), 0);
      cyc(1);
      chk("t6_first", {sx(0)[15:0], 15'd0, move_tick}, {16'd4, 16'd1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
